dmi_host_sequencer: RTL and testbench



---
 rtl/dmi_host_sequencer.sv | 170 +++++++++++++++++
 tb/tb_dmi_host_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_host_sequencer.sv
// dmi_host_sequencer: turns host request edges into single DMI
// transactions with busy retry and an optional response watchdog.
//
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   host_*             level-driven host command and result registers
//   dmi_req_*          valid/ready DMI request channel
//   dmi_resp_*         valid/ready DMI response channel
// Build option: DMI_SEQ_TIMEOUT_EN adds the response watchdog (status 1).
module dmi_host_sequencer #(
  parameter int MaxRetries    = 3,
  parameter int TimeoutCycles = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        host_req_i,
  input  logic        host_wr_i,
  input  logic [6:0]  host_addr_i,
  input  logic [31:0] host_wdata_i,
  output logic [31:0] host_rdata_o,
  output logic [1:0]  host_status_o,
  output logic        host_busy_o,
  output logic        host_done_o,
  output logic        host_overrun_o,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  output logic [1:0]  dmi_req_op_o,
  output logic [6:0]  dmi_req_addr_o,
  output logic [31:0] dmi_req_data_o,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o,
  input  logic [31:0] dmi_resp_data_i,
  input  logic [1:0]  dmi_resp_resp_i
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_e;

  localparam int RW =
    (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

  state_e        state_q;
  logic          req_q;
  logic [1:0]    op_q;
  logic [RW-1:0] retry_q;

  logic       launch;
  logic       can_retry;
  logic       wd_hit;
  logic [1:0] resp_status;

  assign launch = host_req_i & ~req_q;

  assign can_retry = (dmi_resp_resp_i == 2'd3) &&
                     (int'(retry_q) < MaxRetries);

  // resp 1 is reserved by the DMI protocol; treat it as failed
  always_comb begin
    resp_status = 2'd2;
    unique case (1'b1)
      (dmi_resp_resp_i == 2'd0): resp_status = 2'd0;
      (dmi_resp_resp_i == 2'd3): resp_status = 2'd3;
      default:                   resp_status = 2'd2;
    endcase
  end

`ifdef DMI_SEQ_TIMEOUT_EN
  localparam int WW =
    (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [WW-1:0] WdLast = WW'(TimeoutCycles - 1);

  logic [WW-1:0] wd_q;

  assign wd_hit = (wd_q == WdLast);
`else
  localparam int unused_timeout_cycles = TimeoutCycles;

  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= IDLE;
      req_q            <= 1'b1;
      op_q             <= 2'd0;
      retry_q          <= '0;
      host_rdata_o     <= '0;
      host_status_o    <= 2'd0;
      host_busy_o      <= 1'b0;
      host_done_o      <= 1'b0;
      host_overrun_o   <= 1'b0;
      dmi_req_valid_o  <= 1'b0;
      dmi_req_op_o     <= 2'd0;
      dmi_req_addr_o   <= '0;
      dmi_req_data_o   <= '0;
      dmi_resp_ready_o <= 1'b1;
`ifdef DMI_SEQ_TIMEOUT_EN
      wd_q             <= '0;
`endif
    end else begin
      req_q       <= host_req_i;
      host_done_o <= 1'b0;
      if (launch && (state_q != IDLE)) begin
        host_overrun_o <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (launch) begin
            state_q          <= REQ;
            op_q             <= host_wr_i ? 2'd2 : 2'd1;
            retry_q          <= '0;
            host_overrun_o   <= 1'b0;
            host_busy_o      <= 1'b1;
            dmi_req_valid_o  <= 1'b1;
            dmi_req_op_o     <= host_wr_i ? 2'd2 : 2'd1;
            dmi_req_addr_o   <= host_addr_i;
            dmi_req_data_o   <= host_wdata_i;
            dmi_resp_ready_o <= 1'b0;
          end
        end
        REQ: begin
          if (dmi_req_ready_i) begin
            state_q          <= RESP;
            dmi_req_valid_o  <= 1'b0;
            dmi_req_op_o     <= 2'd0;
            dmi_resp_ready_o <= 1'b1;
`ifdef DMI_SEQ_TIMEOUT_EN
            wd_q             <= '0;
`endif
          end
        end
        RESP: begin
          if (dmi_resp_valid_i) begin
            dmi_resp_ready_o <= 1'b0;
            if (can_retry) begin
              state_q         <= REQ;
              retry_q         <= retry_q + RW'(1);
              dmi_req_valid_o <= 1'b1;
              dmi_req_op_o    <= op_q;
            end else begin
              state_q       <= DONE;
              host_done_o   <= 1'b1;
              host_rdata_o  <= dmi_resp_data_i;
              host_status_o <= resp_status;
            end
          end else if (wd_hit) begin
            state_q          <= DONE;
            host_done_o      <= 1'b1;
            host_status_o    <= 2'd1;
            dmi_resp_ready_o <= 1'b0;
          end else begin
`ifdef DMI_SEQ_TIMEOUT_EN
            wd_q <= wd_q + WW'(1);
`endif
          end
        end
        DONE: begin
          state_q          <= IDLE;
          host_busy_o      <= 1'b0;
          dmi_resp_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmi_host_sequencer.sv
// tb_dmi_host_sequencer: directed checks of the DMI host sequencer
// with hand-computed expected values.
module tb_dmi_host_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_req;
  logic        host_wr;
  logic [6:0]  host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic [1:0]  host_status;
  logic        host_busy;
  logic        host_done;
  logic        host_overrun;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [6:0]  req_addr;
  logic [31:0] req_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [1:0]  resp_resp;

  int checks = 0;
  int errors = 0;
  int n_req  = 0;

  always #5 clk = ~clk;

  dmi_host_sequencer #(
    .MaxRetries   (3),
    .TimeoutCycles(16)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .host_req_i      (host_req),
    .host_wr_i       (host_wr),
    .host_addr_i     (host_addr),
    .host_wdata_i    (host_wdata),
    .host_rdata_o    (host_rdata),
    .host_status_o   (host_status),
    .host_busy_o     (host_busy),
    .host_done_o     (host_done),
    .host_overrun_o  (host_overrun),
    .dmi_req_valid_o (req_valid),
    .dmi_req_ready_i (req_ready),
    .dmi_req_op_o    (req_op),
    .dmi_req_addr_o  (req_addr),
    .dmi_req_data_o  (req_data),
    .dmi_resp_valid_i(resp_valid),
    .dmi_resp_ready_o(resp_ready),
    .dmi_resp_data_i (resp_data),
    .dmi_resp_resp_i (resp_resp)
  );

  always @(posedge clk) begin
    if (rst_n && req_valid && req_ready) begin
      n_req <= n_req + 1;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch(input logic wr,
                        input logic [6:0] addr,
                        input logic [31:0] wdata);
    host_req   = 1'b1;
    host_wr    = wr;
    host_addr  = addr;
    host_wdata = wdata;
    cyc(1);
    host_req = 1'b0;
  endtask

  task automatic resp_cycle(input logic [31:0] data,
                            input logic [1:0] resp);
    resp_valid = 1'b1;
    resp_data  = data;
    resp_resp  = resp;
    cyc(1);
    resp_valid = 1'b0;
  endtask

  initial begin
    int base;
    rst_n      = 1'b0;
    host_req   = 1'b0;
    host_wr    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    req_ready  = 1'b1;
    resp_valid = 1'b0;
    resp_data  = '0;
    resp_resp  = 2'd0;
    cyc(2);
    check("rst_valid", req_valid, 0);
    check("rst_op", req_op, 0);
    check("rst_busy", host_busy, 0);
    check("rst_done", host_done, 0);
    check("rst_overrun", host_overrun, 0);
    check("rst_rdata", host_rdata, 0);
    check("rst_status", host_status, 0);
    check("rst_resp_ready", resp_ready, 1);
    rst_n = 1'b1;
    cyc(2);

    // read, minimum latency
    base = n_req;
    launch(1'b0, 7'h11, 32'h0);
    check("rd_valid", req_valid, 1);
    check("rd_op", req_op, 1);
    check("rd_addr", req_addr, 32'h11);
    check("rd_busy", host_busy, 1);
    check("rd_rready", resp_ready, 0);
    cyc(1);
    check("rd_hs_valid", req_valid, 0);
    check("rd_hs_op", req_op, 0);
    check("rd_resp_rdy", resp_ready, 1);
    resp_cycle(32'h0000_0C82, 2'd0);
    check("rd_done", host_done, 1);
    check("rd_rdata", host_rdata, 32'hC82);
    check("rd_status", host_status, 0);
    cyc(1);
    check("rd_done_off", host_done, 0);
    check("rd_idle", host_busy, 0);
    check("rd_nreq", n_req - base, 1);

    // write with backpressure
    req_ready = 1'b0;
    base = n_req;
    launch(1'b1, 7'h10, 32'h1);
    for (int i = 0; i < 4; i++) begin
      check("wr_valid", req_valid, 1);
      check("wr_op", req_op, 2);
      check("wr_addr", req_addr, 32'h10);
      check("wr_data", req_data, 32'h1);
      cyc(1);
    end
    req_ready = 1'b1;
    cyc(1);
    check("wr_hs", req_valid, 0);
    resp_cycle(32'h0, 2'd0);
    check("wr_done", host_done, 1);
    check("wr_status", host_status, 0);
    cyc(1);
    check("wr_nreq", n_req - base, 1);

    // two busy answers then success
    base = n_req;
    launch(1'b0, 7'h04, 32'h0);
    cyc(1);
    resp_cycle(32'h0, 2'd3);
    check("rt_valid1", req_valid, 1);
    check("rt_op1", req_op, 1);
    check("rt_nodone", host_done, 0);
    cyc(1);
    resp_cycle(32'h0, 2'd3);
    check("rt_valid2", req_valid, 1);
    cyc(1);
    resp_cycle(32'h55, 2'd0);
    check("rt_done", host_done, 1);
    check("rt_status", host_status, 0);
    check("rt_rdata", host_rdata, 32'h55);
    cyc(1);
    check("rt_nreq", n_req - base, 3);

    // busy until retries exhausted
    base = n_req;
    launch(1'b1, 7'h05, 32'h9);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      resp_cycle(32'h0, 2'd3);
      check("ex_retry", req_valid, 1);
      check("ex_op", req_op, 2);
    end
    cyc(1);
    resp_cycle(32'hAA, 2'd3);
    check("ex_done", host_done, 1);
    check("ex_status", host_status, 3);
    check("ex_rdata", host_rdata, 32'hAA);
    cyc(1);
    check("ex_nreq", n_req - base, 4);

    // failed response codes
    launch(1'b0, 7'h06, 32'h0);
    cyc(1);
    resp_cycle(32'h66, 2'd2);
    check("f2_status", host_status, 2);
    cyc(1);
    launch(1'b0, 7'h06, 32'h0);
    cyc(1);
    resp_cycle(32'h67, 2'd1);
    check("f1_status", host_status, 2);
    check("f1_rdata", host_rdata, 32'h67);
    cyc(1);

    // level held high for 50 cycles
    base = n_req;
    host_req  = 1'b1;
    host_wr   = 1'b0;
    host_addr = 7'h12;
    cyc(2);
    resp_cycle(32'h7, 2'd0);
    check("lv_done", host_done, 1);
    cyc(47);
    check("lv_nreq", n_req - base, 1);
    check("lv_busy", host_busy, 0);
    check("lv_overrun", host_overrun, 0);
    host_req = 1'b0;
    cyc(1);

    // second edge while busy
    req_ready = 1'b0;
    base = n_req;
    launch(1'b0, 7'h20, 32'h0);
    cyc(1);
    host_addr = 7'h22;
    host_req  = 1'b1;
    cyc(1);
    host_req = 1'b0;
    check("ov_set", host_overrun, 1);
    check("ov_valid", req_valid, 1);
    check("ov_addr", req_addr, 32'h20);
    req_ready = 1'b1;
    cyc(1);
    resp_cycle(32'h1234, 2'd0);
    check("ov_done", host_done, 1);
    check("ov_sticky", host_overrun, 1);
    cyc(1);
    check("ov_nreq", n_req - base, 1);
    launch(1'b0, 7'h21, 32'h0);
    check("ov_clear", host_overrun, 0);
    cyc(1);
    resp_cycle(32'h1234, 2'd0);
    cyc(1);

    // no response
    base = n_req;
    launch(1'b0, 7'h30, 32'h0);
    cyc(1);
`ifdef DMI_SEQ_TIMEOUT_EN
    for (int i = 1; i < 16; i++) begin
      cyc(1);
      check("to_wait", host_done, 0);
    end
    cyc(1);
    check("to_done", host_done, 1);
    check("to_status", host_status, 1);
    check("to_rdata", host_rdata, 32'h1234);
    cyc(1);
    check("to_idle", host_busy, 0);
    check("to_rready", resp_ready, 1);
    resp_cycle(32'hBAD, 2'd0);
    check("to_late_done", host_done, 0);
    check("to_late_rdata", host_rdata, 32'h1234);
    check("to_late_busy", host_busy, 0);
    check("to_nreq", n_req - base, 1);
`else
    cyc(30);
    check("nt_busy", host_busy, 1);
    check("nt_done", host_done, 0);
    resp_cycle(32'h1234, 2'd0);
    check("nt_resp", host_done, 1);
    check("nt_status", host_status, 0);
    cyc(1);
`endif

    // reset in RESP with request held high
    launch(1'b0, 7'h31, 32'h0);
    cyc(1);
    host_req = 1'b1;
    rst_n    = 1'b0;
    #1;
    check("ar_valid", req_valid, 0);
    check("ar_busy", host_busy, 0);
    check("ar_rready", resp_ready, 1);
    check("ar_rdata", host_rdata, 0);
    cyc(2);
    rst_n = 1'b1;
    base  = n_req;
    cyc(5);
    check("ar_nolaunch", host_busy, 0);
    check("ar_novalid", req_valid, 0);
    check("ar_nreq", n_req - base, 0);
    host_req = 1'b0;
    cyc(1);
    launch(1'b0, 7'h11, 32'h0);
    cyc(1);
    resp_cycle(32'h5, 2'd0);
    check("ar_rec_done", host_done, 1);
    check("ar_rec_rdata", host_rdata, 32'h5);
    cyc(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
